bank_rd_streamer: RTL and testbench
===================================

BANK_RD_STREAMER -- requirements
Module: bank_rd_streamer

Interface
REQ-001 The block SHALL have parameter w, default 64, meaning the bank word width in bits.
REQ-002 The block SHALL have parameter a, default 10, meaning the bank address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the output FIFO depth (power of 2, at least 2).
REQ-004 The block SHALL have parameter MUXCODE, default 2'b01, meaning the constant driven on bank_rd_muxcode.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: a one-cycle job request.
REQ-008 The block SHALL have port base_addr, input, a bits: the first word address of the job.
REQ-009 The block SHALL have port len, input, a+1 bits: the word count of the job, 0 to 2^a.
REQ-010 The block SHALL have port stride, input, a bits: the address increment per word (present only with the macro).
REQ-011 The block SHALL have port busy, output, 1 bit: a job is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle job-complete pulse.
REQ-013 The block SHALL have port bank_rd_en, output, 1 bit: the bank read strobe.
REQ-014 The block SHALL have port bank_rd_addr, output, a bits: the bank read address.
REQ-015 The block SHALL have port bank_rd_muxcode, output, 2 bits: the read port select, equal to MUXCODE.
REQ-016 The block SHALL have port bank_rd_word, input, w bits: bank read data, valid one cycle after bank_rd_en.
REQ-017 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-018 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-019 The block SHALL have port out_data, output, w bits: the streamed word.
REQ-020 The block SHALL have port out_last, output, 1 bit: marks the final word of the job.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE and DRAIN.
  - IDLE->ISSUE when start is high and len is non-zero.
  - ISSUE->DRAIN in the cycle the last read is issued.
  - DRAIN->IDLE when the last word is accepted (out_valid & out_ready & out_last).
REQ-022 On start, the block SHALL latch base_addr, len and stride, and SHALL ignore start whenever busy=1.
REQ-023 When start is high with len=0, the block SHALL issue no reads and SHALL pulse done in the next cycle.
REQ-024 In ISSUE, bank_rd_en SHALL assert only when (FIFO occupancy + in-flight reads) < DEPTH.
  - At most one read is issued per cycle.
REQ-025 Bank read latency SHALL be exactly 1 cycle; the returning word SHALL be written into the FIFO in that cycle.
  - The FIFO never overflows.
REQ-026 Read addresses SHALL be base_addr + k*stride, modulo 2^a (wrap-around), for k = 0..len-1.
REQ-027 The output SHALL use a valid/ready handshake.
  - A word transfers when out_valid & out_ready are both high.
  - out_valid, out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 out_last SHALL be high only on the len-th word of the job.
REQ-029 done SHALL pulse in the cycle after the last-word transfer.
  - busy SHALL be 1 from the cycle after an accepted start until done.
REQ-030 With the FIFO empty and out_ready held high, throughput SHALL be 1 word per cycle.
  - Latency from start to first out_valid SHALL be 2 cycles.
REQ-031 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-032 Asserting rst SHALL immediately force the following, including mid-job:
  - FSM to IDLE; FIFO empty; in-flight counter and all counters to 0.
  - busy, done, bank_rd_en, out_valid and out_last to 0.
  - bank_rd_addr and out_data to 0.
REQ-033 After reset is released, the block SHALL issue no read and SHALL NOT pulse done until a new start arrives.

Configuration
REQ-034 With macro BANK_RD_STREAMER_STRIDE_EN defined, the stride port SHALL exist and be latched on start.
REQ-035 Without BANK_RD_STREAMER_STRIDE_EN, the stride port SHALL be absent and the stride SHALL be fixed at 1.

Structure
REQ-036 A shared package bank_pkg SHALL hold:
  - BANK_W=64 and BANK_A=10;
  - the muxcode constants MUX_I=2'b00, MUX_D=2'b01 and MUX_C=2'b10;
  - the FSM state enum.
REQ-037 The FIFO SHALL be one sub-module, rd_stream_fifo: synchronous, first-word-fall-through, parameterised by w and DEPTH.

Verification
REQ-038 Basic job: start with base=0x010, len=4, out_ready=1 -> reads at 0x010..0x013 on 4 consecutive cycles; data in order; out_last on word 4; done one cycle later.
REQ-039 Backpressure: len=8 with out_ready low for 10 cycles -> at most 4 reads issued, stall, then resume; all 8 words delivered in order with none lost.
REQ-040 Wrap: base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-041 Zero length: start with len=0 -> no bank_rd_en; done pulses next cycle; busy stays 0.
REQ-042 Reset mid-job: rst asserted after 3 of 8 words -> all outputs 0 immediately; a new job with len=2 then completes normally.
REQ-043 Stride (macro on): base=0x100, stride=0x040, len=3 -> addresses 0x100, 0x140, 0x180; start asserted while busy is ignored.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared bank definitions: word/address widths, read-port muxcodes and the
// streamer FSM state encoding.
package bank_pkg;

  localparam int BANK_W = 64;
  localparam int BANK_A = 10;

  // Read port select codes.
  localparam logic [1:0] MUX_I = 2'b00;
  localparam logic [1:0] MUX_D = 2'b01;
  localparam logic [1:0] MUX_C = 2'b10;

  // Streamer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rd_stream_fifo.sv
// First-word-fall-through FIFO for the read streamer. When empty, a pushed
// word is presented on the output in the same cycle (bypass), and if it is
// also popped in that cycle it is never written to storage. Output data is
// forced to zero whenever no word is valid.
module rd_stream_fifo #(
  parameter int w     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [w-1:0]             push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [w-1:0]             data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [w-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          empty;
  logic          bypass;
  logic          wr;
  logic          rd;

  assign empty  = (count_q == '0);
  assign bypass = empty & push & pop;
  assign wr     = push & ~bypass;
  assign rd     = pop & ~empty;
  assign valid  = ~empty | push;
  assign count  = count_q;

  // Head of queue, or the incoming word when the queue is empty.
  always_comb begin
    data = '0;
    if (valid) begin
      data = empty ? push_data : mem[rd_ptr];
    end
  end

  // Storage array; no reset needed because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous write and read leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bank_rd_streamer.sv
// Bank read streamer: on start, reads len words from a 1-cycle-latency bank
// at base_addr + k*stride (wrapping modulo 2^a) and streams them out over a
// valid/ready port, marking the final word with out_last.
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high; while out_valid=1 and out_ready=0, out_valid, out_data and
// out_last hold stable.
//
// Optional feature: define BANK_RD_STREAMER_STRIDE_EN to add the stride port;
// without it the address increment is fixed at 1.
module bank_rd_streamer
  import bank_pkg::*;
#(
  parameter int         w       = BANK_W,
  parameter int         a       = BANK_A,
  parameter int         DEPTH   = 4,
  parameter logic [1:0] MUXCODE = MUX_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [a-1:0] base_addr,
  input  logic [a:0]   len,
`ifdef BANK_RD_STREAMER_STRIDE_EN
  input  logic [a-1:0] stride,
`endif
  output logic         busy,
  output logic         done,
  output logic         bank_rd_en,
  output logic [a-1:0] bank_rd_addr,
  output logic [1:0]   bank_rd_muxcode,
  input  logic [w-1:0] bank_rd_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [w-1:0] out_data,
  output logic         out_last
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]  DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [a:0]   ONE_LEN   = {{a{1'b0}}, 1'b1};

  state_e        state;
  logic [a-1:0]  addr_q;
  logic [a-1:0]  stride_v;
  logic [a:0]    rem_q;
  logic [a:0]    len_q;
  logic [a:0]    pop_cnt;
  logic          inflight_q;
  logic          done_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  logic [w-1:0]  fifo_data;
  logic [CW:0]   occupancy;

  logic          start_ok;
  logic          start_zero;
  logic          issue;
  logic          xfer;
  logic          last_xfer;

  // Start is only honoured in IDLE, so a start while busy is dropped.
  assign start_ok   = (state == ST_IDLE) && start && (len != '0);
  assign start_zero = (state == ST_IDLE) && start && (len == '0);

  // Words buffered plus the read whose data arrives next cycle must leave room.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue      = (state == ST_ISSUE) && (occupancy < DEPTH_OCC);

  assign xfer       = fifo_valid && out_ready;
  assign last_xfer  = xfer && out_last;

  assign busy            = (state != ST_IDLE);
  assign done            = done_q;
  assign bank_rd_en      = issue;
  assign bank_rd_addr    = addr_q;
  assign bank_rd_muxcode = MUXCODE;
  assign out_valid       = fifo_valid;
  assign out_data        = fifo_data;
  assign out_last        = fifo_valid && busy && (pop_cnt == len_q - ONE_LEN);

`ifdef BANK_RD_STREAMER_STRIDE_EN
  logic [a-1:0] stride_q;

  // Stride is captured with the rest of the job parameters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q <= '0;
    end else if (start_ok) begin
      stride_q <= stride;
    end
  end

  assign stride_v = stride_q;
`else
  assign stride_v = {{(a-1){1'b0}}, 1'b1};
`endif

  // Job control FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_ok) state <= ST_ISSUE;
        ST_ISSUE: if (issue && (rem_q == ONE_LEN)) state <= ST_DRAIN;
        ST_DRAIN: if (last_xfer) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Address generation, word counters, in-flight flag and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      pop_cnt    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q  <= base_addr;
        rem_q   <= len;
        len_q   <= len;
        pop_cnt <= '0;
      end else begin
        if (issue) begin
          addr_q <= addr_q + stride_v;
          rem_q  <= rem_q - ONE_LEN;
        end
        if (xfer) begin
          pop_cnt <= pop_cnt + ONE_LEN;
        end
      end
      inflight_q <= issue;
      done_q     <= last_xfer || start_zero;
    end
  end

  // Returning bank word goes into the FIFO in the cycle it arrives.
  rd_stream_fifo #(
    .w     (w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (bank_rd_word),
    .pop       (xfer),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_bank_rd_streamer.sv
// Directed bench for bank_rd_streamer with a behavioural 1-cycle bank and a
// scoreboard of expected read addresses and output words.
module tb_bank_rd_streamer;

  localparam int W     = 64;
  localparam int A     = 10;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [A-1:0] base_addr;
  logic [A:0]   len;
`ifdef BANK_RD_STREAMER_STRIDE_EN
  logic [A-1:0] stride;
`endif
  logic         busy;
  logic         done;
  logic         bank_rd_en;
  logic [A-1:0] bank_rd_addr;
  logic [1:0]   bank_rd_muxcode;
  logic [W-1:0] bank_rd_word;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  always #5 clk = ~clk;

  bank_rd_streamer #(
    .w       (W),
    .a       (A),
    .DEPTH   (DEPTH),
    .MUXCODE (2'b01)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .len             (len),
`ifdef BANK_RD_STREAMER_STRIDE_EN
    .stride          (stride),
`endif
    .busy            (busy),
    .done            (done),
    .bank_rd_en      (bank_rd_en),
    .bank_rd_addr    (bank_rd_addr),
    .bank_rd_muxcode (bank_rd_muxcode),
    .bank_rd_word    (bank_rd_word),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last)
  );

  // ---------------- counters and scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [W:0]   exp_q[$];       // {last, data}
  logic [A-1:0] exp_addr_q[$];
  logic [7:0]   salt = 8'h00;

  int reads_total    = 0;
  int accepted_total = 0;
  int outstanding    = 0;

  logic         hold_v = 1'b0;
  logic [W-1:0] hold_data;
  logic         hold_last;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] bank_word(input logic [A-1:0] ad, input logic [7:0] s);
    return {s, 6'h0, ad, 8'h5A, 22'h0, ad};
  endfunction

  // Bank model: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (bank_rd_en) bank_rd_word <= bank_word(bank_rd_addr, salt);
    else            bank_rd_word <= {$urandom, $urandom};
  end

  // Read-side monitor: addresses, unexpected reads, credit limit.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      if (bank_rd_en) begin
        reads_total++;
        check("rd_expected", 72'(exp_addr_q.size() != 0), 72'(1));
        check("rd_credit", 72'(outstanding < DEPTH), 72'(1));
        if (exp_addr_q.size() != 0) check("rd_addr", 72'(bank_rd_addr), 72'(exp_addr_q.pop_front()));
        outstanding++;
      end
      if (out_valid && out_ready) outstanding--;
    end
  end

  // Output-side monitor: word order/content/last, and hold under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 72'(out_valid), 72'(1));
        check("hold_word", 72'({out_last, out_data}), 72'({hold_last, hold_data}));
      end
      if (out_valid && out_ready) begin
        accepted_total++;
        check("out_expected", 72'(exp_q.size() != 0), 72'(1));
        if (exp_q.size() != 0) check("out_word", 72'({out_last, out_data}), 72'(exp_q.pop_front()));
      end
      hold_v    = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [A-1:0] b, input logic [A:0] l, input logic [A-1:0] s);
    logic [A-1:0] ad;
    base_addr = b;
    len       = l;
`ifdef BANK_RD_STREAMER_STRIDE_EN
    stride    = s;
`endif
    for (int k = 0; k < int'(l); k++) begin
      ad = b + A'(k) * s;
      exp_addr_q.push_back(ad);
      exp_q.push_back({(k == int'(l) - 1), bank_word(ad, salt)});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input bit rand_ready);
    int n = 0;
    while (!done && n < max_cycles) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    check("done_seen", 72'(done), 72'(1));
    check("busy_at_done", 72'(busy), 72'(0));
    check("sb_words_empty", 72'(exp_q.size()), 72'(0));
    check("sb_addr_empty", 72'(exp_addr_q.size()), 72'(0));
    tick();
    check("done_one_cycle", 72'(done), 72'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r0;
    int n;
    logic [A-1:0] st;

    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
`ifdef BANK_RD_STREAMER_STRIDE_EN
    stride    = '0;
`endif
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_ctrl", 72'({busy, done, bank_rd_en, out_valid, out_last}), 72'(0));
    check("rst_addr", 72'(bank_rd_addr), 72'(0));
    check("rst_data", 72'(out_data), 72'(0));
    check("muxcode", 72'(bank_rd_muxcode), 72'(2'b01));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_quiet", 72'({busy, done, bank_rd_en}), 72'(0));
    end

    // Basic job: four consecutive reads, 2-cycle latency, last on word 4.
    salt = 8'h11;
    start_job(10'h010, 11'd4, 10'd1);
    check("j1_c1_busy", 72'(busy), 72'(1));
    check("j1_c1_rd", 72'({bank_rd_en, bank_rd_addr}), 72'({1'b1, 10'h010}));
    check("j1_c1_valid", 72'(out_valid), 72'(0));
    tick();
    check("j1_c2_rd", 72'({bank_rd_en, bank_rd_addr}), 72'({1'b1, 10'h011}));
    check("j1_c2_valid", 72'({out_valid, out_last}), 72'(2'b10));
    tick();
    check("j1_c3_rd", 72'({bank_rd_en, bank_rd_addr}), 72'({1'b1, 10'h012}));
    tick();
    check("j1_c4_rd", 72'({bank_rd_en, bank_rd_addr}), 72'({1'b1, 10'h013}));
    check("j1_c4_last", 72'(out_last), 72'(0));
    tick();
    check("j1_c5_rd", 72'(bank_rd_en), 72'(0));
    check("j1_c5_last", 72'({out_valid, out_last, busy, done}), 72'(4'b1110));
    tick();
    check("j1_done", 72'({done, busy, out_valid}), 72'(3'b100));
    tick();
    check("j1_done_low", 72'(done), 72'(0));
    check("j1_sb_empty", 72'(exp_q.size()), 72'(0));

    // Backpressure: reads stop at FIFO depth, then resume with nothing lost.
    salt = 8'h22;
    out_ready = 1'b0;
    r0 = reads_total;
    start_job(10'h020, 11'd8, 10'd1);
    repeat (9) tick();
    check("bp_reads_stalled", 72'(reads_total - r0), 72'(DEPTH));
    check("bp_stall_state", 72'({bank_rd_en, out_valid, busy}), 72'(3'b011));
    out_ready = 1'b1;
    wait_done(40, 1'b0);
    check("bp_reads_total", 72'(reads_total - r0), 72'(8));

    // Wrap-around addressing, with a start while busy that must be ignored.
    salt = 8'h33;
    start_job(10'h3FE, 11'd4, 10'd1);
    tick();
    check("busy_for_ignored_start", 72'(busy), 72'(1));
    base_addr = 10'h055;
    len       = 11'd3;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_done(40, 1'b0);
    repeat (3) tick();
    check("ignored_start_idle", 72'({busy, bank_rd_en}), 72'(0));

    // Zero length: no reads, done next cycle, never busy.
    r0 = reads_total;
    start_job(10'h0AA, 11'd0, 10'd1);
    check("zero_done", 72'({done, busy, bank_rd_en}), 72'(3'b100));
    tick();
    check("zero_after", 72'({done, busy, bank_rd_en}), 72'(0));
    check("zero_no_reads", 72'(reads_total - r0), 72'(0));

    // Reset after three of eight words, then a short job.
    salt = 8'h44;
    r0 = accepted_total;
    start_job(10'h100, 11'd8, 10'd1);
    n = 0;
    while ((accepted_total - r0) < 3 && n < 50) begin
      tick();
      n++;
    end
    check("mid_three_words", 72'(accepted_total - r0), 72'(3));
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", 72'({busy, done, bank_rd_en, out_valid, out_last}), 72'(0));
    check("mid_rst_addr", 72'(bank_rd_addr), 72'(0));
    check("mid_rst_data", 72'(out_data), 72'(0));
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_post_rst_quiet", 72'({busy, done, bank_rd_en, out_valid}), 72'(0));
    end
    salt = 8'h55;
    start_job(10'h200, 11'd2, 10'd1);
    wait_done(20, 1'b0);

`ifdef BANK_RD_STREAMER_STRIDE_EN
    // Strided addressing.
    salt = 8'h66;
    start_job(10'h100, 11'd3, 10'h040);
    wait_done(20, 1'b0);
`endif

    // Random jobs with random backpressure.
    for (int j = 0; j < 4; j++) begin
      salt = 8'(8'h70 + j);
`ifdef BANK_RD_STREAMER_STRIDE_EN
      st = A'($urandom_range(1, 1023));
`else
      st = 10'd1;
`endif
      start_job(A'($urandom_range(0, 1023)), (A+1)'($urandom_range(5, 12)), st);
      wait_done(300, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
